// File: rtl/simple_uart_pkg.sv
// simple_uart_pkg: register map, STATUS/CTRL bit positions and TX FSM states shared by the UART TX block.
package simple_uart_pkg;
    localparam logic [9:0] OFF_TXDATA = 10'h000;
    localparam logic [9:0] OFF_STATUS = 10'h004;
    localparam logic [9:0] OFF_DIV    = 10'h008;
    localparam logic [9:0] OFF_CTRL   = 10'h00C;
    localparam int STATUS_FULL  = 0;
    localparam int STATUS_EMPTY = 1;
    localparam int STATUS_BUSY  = 2;
    localparam int STATUS_OVF   = 3;
    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module uart_tx_fifo #(
    parameter int Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);
    localparam int AW = $clog2(Depth);
    logic [7:0] mem [Depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = level == (AW+1)'(Depth);
    assign empty   = level == '0;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/simple_uart_tx.sv
// simple_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and programmable bit period.
// Define SIMPLE_UART_TX_IRQ_EN to add irq_o and the CTRL[1] IRQ_EN bit.
module simple_uart_tx
    import simple_uart_pkg::*;
#(
    parameter int          DataWidth    = 32,
    parameter int          AddressWidth = 32,
    parameter int          FifoDepth    = 8,
    parameter logic [15:0] DivReset     = 16'd15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    err_o,
`ifdef SIMPLE_UART_TX_IRQ_EN
    output logic                    irq_o,
`endif
    output logic                    tx_o
);
    localparam int LW = $clog2(FifoDepth) + 1;
    tx_state_e state, state_d;
    logic [15:0] div, baud_cnt, baud_d;
    logic [2:0] bit_cnt, bit_d;
    logic [7:0] shift, shift_d, fifo_rdata;
    logic tx_d, tx_en, irq_en, ovf, pop, push, full, empty, tick, mapped, wr;
    logic [LW-1:0] level;
    logic [3:0] level_sat;
    logic [9:0] off;
    logic [31:0] rd_val;
    logic unused_bits;

    assign unused_bits = ^{addr_i[AddressWidth-1:10], be_i[3:1], wdata_i[DataWidth-1:16]};
    assign off       = addr_i[9:0];
    assign mapped    = off inside {OFF_TXDATA, OFF_STATUS, OFF_DIV, OFF_CTRL};
    assign wr        = req_i && we_i && mapped;
    assign push      = wr && off == OFF_TXDATA && be_i[0];
    assign level_sat = (int'(level) > 15) ? 4'hF : 4'(level);
    assign tick      = baud_cnt == '0;
    assign rd_val    = off == OFF_STATUS ? {24'b0, level_sat, ovf, state != IDLE, empty, full} :
                       off == OFF_DIV    ? {16'b0, div} :
                       off == OFF_CTRL   ? {30'b0, irq_en, tx_en} : '0;

    uart_tx_fifo #(.Depth(FifoDepth)) u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (push),
        .pop   (pop),
        .wdata (wdata_i[7:0]),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
            div      <= DivReset;
            tx_en    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            err_o    <= req_i && !mapped;
            rdata_o  <= (req_i && !we_i) ? DataWidth'(rd_val) : '0;
            if (wr && off == OFF_DIV) div <= wdata_i[15:0];
            if (wr && off == OFF_CTRL) tx_en <= wdata_i[CTRL_TX_EN];
            if (push && full && !pop) ovf <= 1'b1;
            else if (wr && off == OFF_STATUS && wdata_i[STATUS_OVF]) ovf <= 1'b0;
        end
    end

`ifdef SIMPLE_UART_TX_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (wr && off == OFF_CTRL) irq_en <= wdata_i[CTRL_IRQ_EN];
            irq_o <= irq_en && empty && state == IDLE;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_o     <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shift    <= shift_d;
            tx_o     <= tx_d;
        end
    end

    // Baud counter reloads from DIV at every bit boundary, so DIV writes take effect on the next bit.
    always_comb begin
        state_d = state;
        baud_d  = tick ? div : baud_cnt - 16'd1;
        bit_d   = bit_cnt;
        shift_d = shift;
        tx_d    = tx_o;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_d = div;
                if (tx_en && !empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift[0];
            end
            DATA: if (tick) begin
                shift_d = shift >> 1;
                bit_d   = bit_cnt + 3'd1;
                tx_d    = shift[1];
                if (bit_cnt == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: if (tick) begin
                state_d = IDLE;
                tx_d    = 1'b1;
                if (tx_en && !empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
